// File: rtl/stack_alu_sequencer.sv
// Command front-end for a stack ALU: takes PUSH/ADD/MUL/POP commands one at a time,
// screens them against the tracked stack depth and returns ALU results over a handshake.
module stack_alu_sequencer #(
    parameter int n     = 16,
    parameter int DEPTH = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [n-1:0]                 cmd_data,
    output logic [2:0]                   alu_opcode,
    output logic [n-1:0]                 alu_data,
    input  logic [n-1:0]                 alu_result,
    input  logic                         alu_overflow,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [n-1:0]                 res_data,
    output logic                         res_overflow,
    output logic                         err,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_POP  = 2'b11;

    localparam logic [2:0] ALU_NOP  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_PUSH = 3'b110;
    localparam logic [2:0] ALU_POP  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESULT,
        REJECT
    } state_t;

    state_t     state_reg;
    logic [1:0] op_reg;
    logic       legal;
    logic [2:0] mapped_opcode;

    // Legality is judged against the depth as it stands when the command is offered.
    always_comb begin
        legal         = 1'b0;
        mapped_opcode = ALU_NOP;
        case (cmd_op)
            OP_PUSH: begin
                legal         = (depth < DEPTH_MAX);
                mapped_opcode = ALU_PUSH;
            end
            OP_ADD: begin
                legal         = (depth > DW'(1));
                mapped_opcode = ALU_ADD;
            end
            OP_MUL: begin
                legal         = (depth > DW'(1));
                mapped_opcode = ALU_MUL;
            end
            default: begin
                legal         = (depth != '0);
                mapped_opcode = ALU_POP;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            op_reg       <= OP_PUSH;
            cmd_ready    <= 1'b1;
            alu_opcode   <= ALU_NOP;
            alu_data     <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_overflow <= 1'b0;
            err          <= 1'b0;
            depth        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        op_reg    <= cmd_op;
                        cmd_ready <= 1'b0;
                        if (legal) begin
                            state_reg  <= ISSUE;
                            alu_opcode <= mapped_opcode;
                            alu_data   <= cmd_data;
                        end else begin
                            state_reg <= REJECT;
                            err       <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    alu_opcode <= ALU_NOP;
                    if (op_reg == OP_PUSH) begin
                        depth     <= depth + DW'(1);
                        cmd_ready <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        depth     <= depth - DW'(1);
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // ALU outputs settled after the edge that sampled the opcode.
                    res_data     <= alu_result;
                    res_overflow <= alu_overflow;
                    res_valid    <= 1'b1;
                    state_reg    <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                REJECT: begin
                    err       <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
